// File: rtl/enc_data_slicer_pkg.sv
// Shared definitions for the encoder-to-decoder frame slicer.
package enc_data_slicer_pkg;

  localparam int unsigned MAX_CODE_RATE    = 3;
  localparam int unsigned SLICED_INPUT_NUM = 2 * MAX_CODE_RATE;
  localparam int unsigned FRAME_BITS       = 384;
  localparam int unsigned FRAME_STEPS      = 128;
  localparam int unsigned BEATS_PER_FRAME  = FRAME_STEPS / 2;

  localparam int unsigned IDX_W  = $clog2(FRAME_BITS);
  localparam int unsigned STEP_W = $clog2(FRAME_STEPS);
  localparam int unsigned BEAT_W = $clog2(BEATS_PER_FRAME);

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } slicer_state_t;

endpackage

// File: rtl/enc_data_slicer.sv
// Captures one encoded frame on the rising edge of encoder-done and streams it
// out two trellis steps per beat under a valid/ready handshake.
module enc_data_slicer
  import enc_data_slicer_pkg::*;
#(
  parameter int unsigned FRAME_W   = FRAME_BITS,
  parameter int unsigned SLICE_W   = SLICED_INPUT_NUM,
  parameter int unsigned NUM_BEATS = BEATS_PER_FRAME
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_encoder_done,
  input  logic [FRAME_W-1:0] i_encoder_data,
  input  logic               i_code_rate,
  input  logic               i_ready,
  output logic [SLICE_W-1:0] o_slice_data,
  output logic               o_slice_valid,
  output logic               o_slice_last,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_overrun
);

  slicer_state_t       r_state;
  slicer_state_t       w_state_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [FRAME_W-1:0]  r_data;
  logic                r_rate;
  logic                r_done_q;
  logic                r_overrun;

  logic                w_done_rise;
  logic                w_accept;
  logic                w_last_beat;
  logic [STEP_W-1:0]   w_step1;
  logic [STEP_W-1:0]   w_step2;

  // Symbol for one trellis step. The frame is MSB-first, so step s starts at
  // bit (FRAME_W-1 - rate*s) and walks downward. Rate 1/2 carries two code
  // bits per step; the third symbol bit is forced to zero.
  function automatic logic [2:0] get_sym(
    input logic [FRAME_W-1:0] data,
    input logic               rate,
    input logic [STEP_W-1:0]  step
  );
    logic [IDX_W-1:0] top;
    logic [IDX_W-1:0] step_x;
    logic [2:0]       sym;
    sym    = '0;
    step_x = IDX_W'(step);
    if (rate == CODE_RATE_3) begin
      top    = IDX_W'(FRAME_W - 1) - (step_x + (step_x << 1));
      sym[0] = data[top];
      sym[1] = data[top - IDX_W'(1)];
      sym[2] = data[top - IDX_W'(2)];
    end else begin
      top    = IDX_W'(FRAME_W - 1) - (step_x << 1);
      sym[0] = data[top];
      sym[1] = data[top - IDX_W'(1)];
    end
    return sym;
  endfunction

  assign w_done_rise = i_encoder_done & ~r_done_q;
  assign w_accept    = (r_state == SEND) & i_ready;
  assign w_last_beat = (r_beat == BEAT_W'(NUM_BEATS - 1));
  assign w_step1     = {r_beat, 1'b0};
  assign w_step2     = {r_beat, 1'b1};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: capture on a done edge, leave SEND after the last beat
  // is accepted, and spend exactly one cycle in DONE for the completion pulse.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_done_rise) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (w_accept && w_last_beat) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Frame capture, beat counter, done edge history and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q  <= 1'b0;
      r_data    <= '0;
      r_rate    <= 1'b0;
      r_beat    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= i_encoder_done;
      if ((r_state == IDLE) && w_done_rise) begin
        r_data <= i_encoder_data;
        r_rate <= i_code_rate;
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      if (w_done_rise && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Output decode from state; slice data is zero outside SEND.
  always_comb begin
    o_slice_data  = '0;
    o_slice_valid = 1'b0;
    o_slice_last  = 1'b0;
    o_busy        = 1'b0;
    o_frame_done  = 1'b0;
    o_overrun     = r_overrun;
    case (r_state)
      SEND: begin
        o_slice_valid = 1'b1;
        o_busy        = 1'b1;
        o_slice_last  = w_last_beat;
        o_slice_data  = {get_sym(r_data, r_rate, w_step2),
                         get_sym(r_data, r_rate, w_step1)};
      end
      DONE: begin
        o_frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_enc_data_slicer.sv
// Directed bench for enc_data_slicer: frames at both code rates, handshake
// stalls, overrun, mid-frame reset and held encoder-done.
module tb_enc_data_slicer;
  import enc_data_slicer_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_encoder_done;
  logic [383:0] i_encoder_data;
  logic         i_code_rate;
  logic         i_ready;
  logic [5:0]   o_slice_data;
  logic         o_slice_valid;
  logic         o_slice_last;
  logic         o_busy;
  logic         o_frame_done;
  logic         o_overrun;

  int checks = 0;
  int errors = 0;

  enc_data_slicer #(.FRAME_W(384), .SLICE_W(6), .NUM_BEATS(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_encoder_done (i_encoder_done),
    .i_encoder_data (i_encoder_data),
    .i_code_rate    (i_code_rate),
    .i_ready        (i_ready),
    .o_slice_data   (o_slice_data),
    .o_slice_valid  (o_slice_valid),
    .o_slice_last   (o_slice_last),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference slice: bit positions computed directly from the frame layout.
  function automatic logic [5:0] exp_slice(input logic [383:0] d, input logic r, input int b);
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < 2; k++) begin
      int step;
      step = 2 * b + k;
      for (int j = 0; j < 3; j++) begin
        if (r == CODE_RATE_3) s[3*k+j] = d[383 - 3*step - j];
        else if (j < 2)       s[3*k+j] = d[383 - 2*step - j];
      end
    end
    return s;
  endfunction

  function automatic logic [383:0] rand_frame();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_encoder_done = 1'b0;
    i_encoder_data = '0;
    i_code_rate = CODE_RATE_2;
    i_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start_frame(input logic [383:0] d, input logic r);
    i_encoder_done = 1'b0;
    i_ready = 1'b0;
    @(posedge clk); #1;
    i_encoder_data = d;
    i_code_rate = r;
    i_encoder_done = 1'b1;
    checks++;
    if (o_slice_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_pre_valid got %b exp 0", o_slice_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_slice_valid !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency valid/busy got %b%b exp 11", o_slice_valid, o_busy);
    end
  endtask

  // Streams a captured frame to completion; returns at the DONE-state sample.
  task automatic run_stream(input logic [383:0] d, input logic r, input bit rand_ready,
                            input int drop_at, input int raise_at, input bit perturb,
                            output int nvalid);
    int b = 0;
    bit stalled = 0, dropped = 0, raised = 0, fin = 0, acc;
    logic [5:0] pd;
    logic pl;
    nvalid = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      acc = 0;
      if (o_slice_valid) begin
        nvalid++;
        checks++;
        if (o_slice_data !== exp_slice(d, r, b)) begin
          errors++;
          $display("FAIL slice beat %0d got %b exp %b", b, o_slice_data, exp_slice(d, r, b));
        end
        checks++;
        if (o_slice_last !== (b == 63)) begin
          errors++;
          $display("FAIL last beat %0d got %b exp %b", b, o_slice_last, (b == 63));
        end
        if (stalled) begin
          checks++;
          if (o_slice_data !== pd || o_slice_last !== pl) begin
            errors++;
            $display("FAIL stall_hold beat %0d got %b/%b exp %b/%b", b, o_slice_data, o_slice_last, pd, pl);
          end
        end
        if (drop_at == b && !dropped) begin
          i_encoder_done = 1'b0;
          dropped = 1;
        end
        if (raise_at == b && !raised) begin
          i_encoder_done = 1'b1;
          raised = 1;
          if (perturb) begin
            i_encoder_data = ~d;
            i_code_rate = ~r;
          end
        end
        i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        pd = o_slice_data;
        pl = o_slice_last;
        stalled = !i_ready;
        acc = i_ready;
      end else begin
        checks++;
        errors++;
        $display("FAIL valid_gap beat %0d got 0 exp 1", b);
        i_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (b == 63) begin
          fin = 1;
          checks++;
          if (o_frame_done !== 1'b1 || o_slice_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done/valid/busy got %b%b%b exp 100", o_frame_done, o_slice_valid, o_busy);
          end
        end else begin
          b++;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout stopped at beat %0d exp 64 beats", b);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_slice_data, o_slice_valid, o_slice_last, o_busy, o_frame_done, o_overrun} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {o_slice_data, o_slice_valid, o_slice_last, o_busy, o_frame_done, o_overrun});
    end
  endtask

  // Rate 1/2 single MSB set; afterwards encoder-done stays high with no re-capture.
  task automatic test_rate2_and_hold();
    logic [383:0] d;
    int nv;
    d = '0;
    d[383] = 1'b1;
    start_frame(d, CODE_RATE_2);
    checks++;
    if (o_slice_data !== 6'b000_001) begin
      errors++;
      $display("FAIL rate2_beat0 got %b exp 000001", o_slice_data);
    end
    run_stream(d, CODE_RATE_2, 0, -1, -1, 0, nv);
    checks++;
    if (nv != 64) begin
      errors++;
      $display("FAIL rate2_valid_cycles got %0d exp 64", nv);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_slice_valid !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL hold_no_recapture cyc %0d valid/done/busy got %b%b%b exp 000",
                 i, o_slice_valid, o_frame_done, o_busy);
      end
    end
  endtask

  task automatic test_rate3_pattern();
    logic [383:0] d;
    int nv;
    d = '0;
    d[383] = 1'b1;
    d[382] = 1'b1;
    start_frame(d, CODE_RATE_3);
    checks++;
    if (o_slice_data !== 6'b000_011) begin
      errors++;
      $display("FAIL rate3_beat0 got %b exp 000011", o_slice_data);
    end
    run_stream(d, CODE_RATE_3, 0, -1, -1, 0, nv);
  endtask

  task automatic test_random_ready();
    logic [383:0] d;
    int nv;
    d = rand_frame();
    start_frame(d, CODE_RATE_3);
    run_stream(d, CODE_RATE_3, 1, -1, -1, 0, nv);
    d = rand_frame();
    start_frame(d, CODE_RATE_2);
    run_stream(d, CODE_RATE_2, 1, -1, -1, 0, nv);
  endtask

  // New done edge at beat 10 with different data/rate presented: frame unchanged.
  task automatic test_overrun();
    logic [383:0] d;
    int nv;
    d = rand_frame();
    start_frame(d, CODE_RATE_3);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got %b exp 0", o_overrun);
    end
    run_stream(d, CODE_RATE_3, 0, 5, 10, 1, nv);
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b exp 1", o_overrun);
    end
  endtask

  task automatic test_reset_midframe();
    logic [383:0] d;
    int nv;
    d = rand_frame();
    start_frame(d, CODE_RATE_2);
    i_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (o_slice_data !== exp_slice(d, CODE_RATE_2, 30)) begin
      errors++;
      $display("FAIL midframe_beat30 got %b exp %b", o_slice_data, exp_slice(d, CODE_RATE_2, 30));
    end
    rst = 1'b1;
    i_encoder_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({o_slice_valid, o_busy, o_slice_last, o_frame_done, o_overrun} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs valid/busy/last/done/ovr got %b exp 00000",
               {o_slice_valid, o_busy, o_slice_last, o_frame_done, o_overrun});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_frame_done !== 1'b0 || o_slice_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cyc %0d done/valid got %b%b exp 00", i, o_frame_done, o_slice_valid);
      end
    end
    d = rand_frame();
    start_frame(d, CODE_RATE_3);
    run_stream(d, CODE_RATE_3, 0, -1, -1, 0, nv);
  endtask

  // Done edge arriving while in DONE is ignored for capture but flags overrun.
  task automatic test_back_to_back();
    logic [383:0] d;
    int nv;
    d = rand_frame();
    start_frame(d, CODE_RATE_2);
    run_stream(d, CODE_RATE_2, 0, 60, -1, 0, nv);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun_pre got %b exp 0", o_overrun);
    end
    i_encoder_done = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_slice_valid !== 1'b0 || o_frame_done !== 1'b0 || o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_done valid/done/ovr got %b%b%b exp 001", o_slice_valid, o_frame_done, o_overrun);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_slice_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_no_capture cyc %0d got %b exp 0", i, o_slice_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rate2_and_hold();
    test_rate3_pattern();
    test_random_ready();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
